ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the board to the keyboard, the opposite direction of the existing `ps2_keyboard` receive path. It drives the shared PS/2 lines through open-drain enables. It follows the device-generated clock, reports the device acknowledge, and raises `rx_inhibit` so the receiver ignores line activity during a host frame.

## Interface

Parameters:
- `INHIBIT_CYCLES`, default 5000: `clk` cycles that `ps2_clk` is held low before the request (100 µs at 50 MHz).
- `START_CYCLES`, default 50: `clk` cycles that data is held low, with clock still low, before the clock is released.
- `TIMEOUT_CYCLES`, default 1000000: frame watchdog limit, in `clk` cycles, counted from clock release.

Ports:
- `clk` input 1: system clock; all logic on its rising edge.
- `clrn` input 1: synchronous, active-high reset.
- `ps2_clk` input 1: PS/2 clock pin level, asynchronous.
- `ps2_data` input 1: PS/2 data pin level, asynchronous.
- `ps2_clk_oe` output 1: 1 pulls the clock line low; 0 releases it.
- `ps2_data_oe` output 1: 1 pulls the data line low; 0 releases it.
- `send_data` input 8: byte to transmit.
- `send_valid` input 1: request to transmit `send_data`.
- `send_ready` output 1: block is idle and will accept a byte.
- `busy` output 1: a frame is in progress.
- `rx_inhibit` output 1: equal to `busy`; the receiver must discard data while it is 1.
- `done` output 1: one-cycle pulse when a frame ends normally.
- `ack_ok` output 1: valid when `done` pulses; 1 means the device pulled data low on the ack bit.
- `err_timeout` output 1: one-cycle pulse when a frame is aborted by the watchdog.

## Operation

- Input sync:
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer.
  - A third register on the clock detects falling edges (`fall` = previous 1, current 0).
- Accept: in IDLE, `send_valid && send_ready` latches `send_data` into the shift register and computes odd parity (`~^send_data`).
  - `send_valid` is ignored outside IDLE.
- States:
  - IDLE: both oe = 0, `send_ready` = 1. Goes to INHIBIT on accept.
  - INHIBIT: `ps2_clk_oe` = 1 for INHIBIT_CYCLES cycles, then goes to START.
  - START: `ps2_clk_oe` = 1 and `ps2_data_oe` = 1 (start bit 0) for START_CYCLES cycles.
    - Then `ps2_clk_oe` = 0, the bit counter is cleared, the watchdog is cleared, and the state goes to SHIFT.
  - SHIFT: on each `fall`, the counter increments and the data line is driven as follows.
    - Edges 1–8: `ps2_data_oe` = ~bit[n-1], data LSB first.
    - Edge 9: `ps2_data_oe` = ~parity.
    - Edge 10: `ps2_data_oe` = 0 (stop bit, line released). Goes to ACK.
  - ACK: on the next `fall`, `ack_ok` latches `~ps2_data` (synchronized). Goes to WAIT_IDLE.
  - WAIT_IDLE: waits until synchronized clock = 1 and data = 1 in the same cycle. Then pulses `done` and returns to IDLE.
- Data is changed only right after a falling edge (device clock low), so the device samples stable data on its rising edge.
- Watchdog (when enabled): counts every cycle in SHIFT, ACK and WAIT_IDLE. On reaching TIMEOUT_CYCLES:
  - both oe = 0;
  - `err_timeout` pulses, `done` does not pulse, `ack_ok` = 0;
  - state goes to IDLE.
- Reset: forces IDLE from any state on the next edge. Both lines are released, and any partially sent frame is abandoned with no `done` or `err_timeout` pulse.

## Timing

- Reset values: `ps2_clk_oe` = 0, `ps2_data_oe` = 0, `send_ready` = 1, `busy` = 0, `rx_inhibit` = 0, `done` = 0, `ack_ok` = 0, `err_timeout` = 0. Shift register, counters and synchronizers are cleared to the idle-line values.
- Accept cycle N:
  - `send_ready` = 0 and `busy` = 1 from cycle N+1;
  - `ps2_clk_oe` = 1 from N+1.
- `ps2_data_oe` rises at N+1+INHIBIT_CYCLES.
- `ps2_clk_oe` falls at N+1+INHIBIT_CYCLES+START_CYCLES.
- Edge response: a pin falling edge updates `ps2_data_oe` 3 `clk` cycles later (2 sync + 1 edge register). This is well inside the ≥5 µs device low phase.
- `done` and `err_timeout` are mutually exclusive, registered, and exactly one cycle wide.
- `busy` drops, and `send_ready` rises, in the cycle after `done` or `err_timeout`.
- Back-to-back: a byte can be accepted in the cycle after `send_ready` returns to 1.
- A falling edge in the same cycle as the watchdog limit: the timeout wins.

## Configuration

- `PS2_TX_TIMEOUT_EN`:
  - Defined: the watchdog is built as described and `err_timeout` is live.
  - Undefined: no watchdog counter, `err_timeout` is tied to 0, and a silent device leaves the block in SHIFT, ACK or WAIT_IDLE until reset.

## Test plan

- Send 0xED with a device model clocking at 12 kHz and acking. Required: line bits 0,1,0,1,1,0,1,1,1, parity 1, stop 1; `done` pulses; `ack_ok` = 1.
- Send 0x07. Required: parity 0; the device model sees stop = 1; `done` pulses with `ack_ok` = 1.
- Device does not pull data low on the 11th edge. Required: `done` pulses with `ack_ok` = 0.
- Device never clocks (macro defined, TIMEOUT_CYCLES = 2000). Required: `err_timeout` pulses 2000 cycles after clock release; both oe = 0; `send_ready` = 1 one cycle later.
- `send_valid` held while `busy` with a different byte. Required: it is ignored; only the first byte appears on the line, and the second is accepted after `send_ready` returns.
- Assert `clrn` after the 5th falling edge. Required: both oe = 0 the next cycle; no `done` or `err_timeout`; the next frame completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device transmitter.
//
// Sends one command byte to a PS/2 device over the shared open-drain lines.
// The host inhibits the bus, issues the request-to-send (start bit with the
// clock held low), releases the clock and then follows the device clock:
// each bit is placed on the line right after a device falling edge, so the
// device samples stable data on its rising edge. The device acknowledge is
// sampled on the 11th falling edge.
//
// Ports:
//   clk, clrn            system clock, synchronous active-high reset
//   ps2_clk, ps2_data    raw PS/2 pin levels (asynchronous)
//   ps2_clk_oe           1 pulls the clock line low
//   ps2_data_oe          1 pulls the data line low
//   send_data/valid      byte to transmit and its request
//   send_ready           idle, a byte will be accepted
//   busy, rx_inhibit     a frame is in progress (receiver must ignore line)
//   done, ack_ok         frame finished; ack_ok = device acknowledged
//   err_timeout          frame aborted by the watchdog
//
// Build option: define PS2_TX_TIMEOUT_EN to build the frame watchdog.
// Without it err_timeout is tied to 0 and a silent device holds the block
// until reset.

module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int START_CYCLES   = 50,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic [7:0] send_data,
   input  logic       send_valid,
   output logic       send_ready,
   output logic       busy,
   output logic       rx_inhibit,
   output logic       done,
   output logic       ack_ok,
   output logic       err_timeout
);

   // One counter times the inhibit and start phases and, once the clock is
   // released, serves as the frame watchdog.
   localparam int MAXC = (INHIBIT_CYCLES > START_CYCLES)
                         ? ((INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES)
                         : ((START_CYCLES > TIMEOUT_CYCLES) ? START_CYCLES : TIMEOUT_CYCLES);
   localparam int CW = $clog2(MAXC + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] ST_LAST  = CW'(START_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_START, S_SHIFT, S_ACK, S_WAIT_IDLE, S_FINISH
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [3:0]    bitcnt;
   logic [7:0]    shreg;
   logic          parity;
   logic          data_drv;
   logic          ack_r;
   logic          clk_s1, clk_s2, clk_s3;
   logic          dat_s1, dat_s2;
   logic          fall;
   logic          accept;
   logic          timeout;
`ifdef PS2_TX_TIMEOUT_EN
   logic          to_r;
`endif

   assign fall = clk_s3 & ~clk_s2;

   // State register
   always_ff @(posedge clk) begin
      if (clrn) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next state and outputs
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      timeout   = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      timeout = ((state == S_SHIFT) || (state == S_ACK) || (state == S_WAIT_IDLE))
                && (cnt == CW'(TIMEOUT_CYCLES - 1));
`endif
      case (state)
         S_IDLE:      if (send_valid) begin
                         accept    = 1'b1;
                         state_nxt = S_INHIBIT;
                      end
         S_INHIBIT:   if (cnt == INH_LAST) state_nxt = S_START;
         S_START:     if (cnt == ST_LAST) state_nxt = S_SHIFT;
         S_SHIFT:     if (fall && (bitcnt == 4'd9)) state_nxt = S_ACK;
         S_ACK:       if (fall) state_nxt = S_WAIT_IDLE;
         S_WAIT_IDLE: if (clk_s2 && dat_s2) state_nxt = S_FINISH;
         S_FINISH:    state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
      // The watchdog overrides any edge seen in the same cycle.
      if (timeout) state_nxt = S_FINISH;

      send_ready  = (state == S_IDLE);
      busy        = (state != S_IDLE);
      rx_inhibit  = busy;
      ps2_clk_oe  = (state == S_INHIBIT) || (state == S_START);
      ps2_data_oe = (state == S_START) || ((state == S_SHIFT) && data_drv);
      ack_ok      = ack_r;
`ifdef PS2_TX_TIMEOUT_EN
      done        = (state == S_FINISH) && !to_r;
      err_timeout = (state == S_FINISH) && to_r;
`else
      done        = (state == S_FINISH);
      err_timeout = 1'b0;
`endif
   end

   // Synchronizers, counters and shift datapath
   always_ff @(posedge clk) begin
      if (clrn) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_s3   <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
         cnt      <= '0;
         bitcnt   <= '0;
         shreg    <= '0;
         parity   <= 1'b0;
         data_drv <= 1'b0;
         ack_r    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
         to_r     <= 1'b0;
`endif
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         clk_s3 <= clk_s2;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;

         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (accept) begin
                  shreg  <= send_data;
                  parity <= ~^send_data;
                  ack_r  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
                  to_r   <= 1'b0;
`endif
               end
            end
            S_INHIBIT: cnt <= (state_nxt != state) ? '0 : cnt + 1'b1;
            S_START: begin
               if (state_nxt != state) begin
                  cnt      <= '0;
                  bitcnt   <= '0;
                  data_drv <= 1'b1;   // keep the start bit on the line until edge 1
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_SHIFT, S_ACK, S_WAIT_IDLE: begin
`ifdef PS2_TX_TIMEOUT_EN
               cnt <= cnt + 1'b1;
`endif
               if (timeout) begin
                  data_drv <= 1'b0;
                  ack_r    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
                  to_r     <= 1'b1;
`endif
               end else if (fall && (state == S_SHIFT)) begin
                  bitcnt <= bitcnt + 1'b1;
                  if (bitcnt < 4'd8)       data_drv <= ~shreg[bitcnt[2:0]];
                  else if (bitcnt == 4'd8) data_drv <= ~parity;
                  else                     data_drv <= 1'b0;
               end else if (fall && (state == S_ACK)) begin
                  ack_r <= ~dat_s2;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- bench for ps2_host_tx with an open-drain PS/2 device model.
// Bytes accepted by the DUT are queued by a monitor; the device model pops them
// and compares the bits it clocks off the line. Expected acknowledge values are
// queued by the device model and compared when done pulses.

module tb_ps2_host_tx;

   localparam int INH  = 20;
   localparam int STC  = 5;
   localparam int TO   = 2000;
   localparam int HALF = 40;

   logic       clk = 1'b0;
   logic       clrn = 1'b1;
   logic       ps2_clk_oe, ps2_data_oe;
   logic [7:0] send_data = 8'h00;
   logic       send_valid = 1'b0;
   logic       send_ready, busy, rx_inhibit, done, ack_ok, err_timeout;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       clk_line, data_line;

   assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
   assign data_line = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_CYCLES(STC), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .clrn(clrn), .ps2_clk(clk_line), .ps2_data(data_line),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
      .send_data(send_data), .send_valid(send_valid), .send_ready(send_ready),
      .busy(busy), .rx_inhibit(rx_inhibit), .done(done), .ack_ok(ack_ok),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   logic [7:0] exp_q[$];
   logic       ack_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Monitor: accepts, phase timing, done/err pulses
   int  cyc = 0, acc_cyc = 0, clk_on_cyc = 0, data_on_cyc = 0, clk_off_cyc = 0, err_cyc = 0;
   int  done_cnt = 0, err_cnt = 0;
   bit  data_seen = 0, clk_off_seen = 0, fin_prev = 0, prev_clk_oe = 0, prev_data_oe = 0;

   always @(negedge clk) begin
      cyc++;
      if (fin_prev && !clrn) check_eq("ready_after_end", {30'd0, send_ready, rx_inhibit}, 32'h2);
      fin_prev = (done || err_timeout) && !clrn;
      if (done || err_timeout) check_eq("done_err_excl", done & err_timeout, 0);
      if (done) begin
         done_cnt++;
         check_eq("busy_at_done", busy, 1);
         if (ack_q.size() == 0) check_eq("ack_q_nonempty", 0, 1);
         else check_eq("ack_ok", ack_ok, ack_q.pop_front());
      end
      if (err_timeout) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (send_valid && send_ready && !clrn) begin
         exp_q.push_back(send_data);
         acc_cyc = cyc;
         data_seen = 0;
         clk_off_seen = 0;
      end
      if (ps2_clk_oe && !prev_clk_oe) clk_on_cyc = cyc;
      if (ps2_data_oe && !prev_data_oe && !data_seen) begin
         data_on_cyc = cyc;
         data_seen = 1;
      end
      if (!ps2_clk_oe && prev_clk_oe && !clk_off_seen) begin
         clk_off_cyc = cyc;
         clk_off_seen = 1;
      end
      prev_clk_oe  = ps2_clk_oe;
      prev_data_oe = ps2_data_oe;
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      send_valid = 1'b1;
      send_data  = b;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (send_ready) break;
      end
      @(posedge clk); #1;
      send_valid = 1'b0;
   endtask

   // Device model: waits for the request, clocks 11 bits, samples on rises.
   // abort_at > 0 pulses clrn after that falling edge instead of finishing.
   task automatic dev_frame(input bit do_ack, input int abort_at);
      logic [9:0] got;
      logic [7:0] e;
      bit         req = 0;
      got = '0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!ps2_clk_oe && !data_line) begin
            req = 1;
            break;
         end
      end
      if (!req) begin
         check_eq("dev_request", 0, 1);
         return;
      end
      for (int i = 1; i <= 11; i++) begin
         repeat (HALF) @(posedge clk);
         #1;
         if (i == 11 && do_ack) dev_data_low = 1'b1;
         dev_clk_low = 1'b1;
         if (i == abort_at) begin
            repeat (6) @(posedge clk);
            #1 clrn = 1'b1;
            @(posedge clk); #1 clrn = 1'b0;
            @(negedge clk);
            check_eq("abort_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
            dev_clk_low = 1'b0;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            return;
         end
         repeat (HALF) @(posedge clk);
         #1;
         if (i <= 10) got[i-1] = data_line;
         dev_clk_low = 1'b0;
         if (i == 11) dev_data_low = 1'b0;
      end
      if (exp_q.size() == 0) begin
         check_eq("exp_q_nonempty", 0, 1);
      end else begin
         e = exp_q.pop_front();
         check_eq("line_byte", got[7:0], e);
         check_eq("line_parity", got[8], ($countones(e) % 2 == 0) ? 1 : 0);
         check_eq("line_stop", got[9], 1);
      end
      ack_q.push_back(do_ack);
   endtask

   task automatic wait_done(input int d0);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done_cnt > d0) break;
      end
      check_eq("done_pulse", done_cnt - d0, 1);
   endtask

   int d0, e0;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
      check_eq("rst_ready", send_ready, 1);
      check_eq("rst_busy", {30'd0, busy, rx_inhibit}, 0);
      check_eq("rst_flags", {29'd0, done, ack_ok, err_timeout}, 0);
      @(posedge clk); #1 clrn = 1'b0;
      repeat (2) @(posedge clk);

      // 0xED with ack, plus phase timing
      d0 = done_cnt;
      fork
         send_byte(8'hED);
         dev_frame(1, 0);
      join
      wait_done(d0);
      check_eq("clk_oe_rise", clk_on_cyc - acc_cyc, 1);
      check_eq("data_oe_rise", data_on_cyc - acc_cyc, 1 + INH);
      check_eq("clk_oe_fall", clk_off_cyc - acc_cyc, 1 + INH + STC);

      // 0x07 with ack (parity 0)
      d0 = done_cnt;
      fork
         send_byte(8'h07);
         dev_frame(1, 0);
      join
      wait_done(d0);

      // 0x5A without ack
      d0 = done_cnt;
      fork
         send_byte(8'h5A);
         dev_frame(0, 0);
      join
      wait_done(d0);

      // send_valid held through a frame with a changed byte
      d0 = done_cnt;
      @(posedge clk); #1;
      send_valid = 1'b1;
      send_data  = 8'hA5;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (send_ready) break;
      end
      @(posedge clk); #1 send_data = 8'h3C;
      dev_frame(1, 0);
      wait_done(d0);
      d0 = done_cnt;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (send_ready) break;
      end
      @(posedge clk); #1 send_valid = 1'b0;
      dev_frame(1, 0);
      wait_done(d0);

      // reset after the 5th falling edge, then a normal frame
      d0 = done_cnt;
      e0 = err_cnt;
      fork
         send_byte(8'h96);
         dev_frame(1, 5);
      join
      repeat (20) @(negedge clk);
      check_eq("abort_no_done", done_cnt - d0, 0);
      check_eq("abort_no_err", err_cnt - e0, 0);
      check_eq("abort_ready", send_ready, 1);
      fork
         send_byte(8'hF0);
         dev_frame(1, 0);
      join
      wait_done(d0);

      // silent device
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(8'hFF);
`ifdef PS2_TX_TIMEOUT_EN
      for (int i = 0; i < TO + 200; i++) begin
         @(negedge clk);
         if (err_timeout) break;
      end
      check_eq("err_pulse", err_cnt - e0, 1);
      check_eq("err_delay", err_cyc - clk_off_cyc, TO);
      check_eq("err_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
      check_eq("err_ack_ok", ack_ok, 0);
      @(negedge clk);
      check_eq("err_ready", send_ready, 1);
`else
      repeat (TO + 100) @(negedge clk);
      check_eq("silent_no_err", err_cnt - e0, 0);
      check_eq("silent_busy", busy, 1);
      @(posedge clk); #1 clrn = 1'b1;
      @(posedge clk); #1 clrn = 1'b0;
      @(negedge clk);
      check_eq("silent_reset_ready", send_ready, 1);
`endif
      check_eq("silent_no_done", done_cnt - d0, 0);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      check_eq("exp_q_drained", exp_q.size(), 0);
      check_eq("ack_q_drained", ack_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
